mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Sequencing controller and round-robin arbiter that shares one combinational 4x4 unsigned carry-save multiplier among NUM_REQ requesters.
- Registers the winner's operands onto the multiplier inputs and waits SETTLE_CYCLES for the array to settle.
- Captures the 8-bit product and returns it with a one-cycle valid pulse to the winning requester.
- Sits between requester logic and a single multiplier instance, which is instantiated outside this block.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- SETTLE_CYCLES, 1, cycles the multiplier inputs are held before the product is captured; minimum 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  request level, one bit per requester.
- req_factor1  in  4*NUM_REQ  operand A of each requester, flattened; requester i uses bits [4i+3:4i].
- req_factor2  in  4*NUM_REQ  operand B of each requester, flattened; same packing as req_factor1.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
- product  out  8  last captured product; holds its value between results.
- busy  out  1  high in every state except IDLE.
- mul_factor1  out  4  registered operand A driven to the multiplier.
- mul_factor2  out  4  registered operand B driven to the multiplier.
- mul_product  in  8  multiplier result; only bits [7:0] are used.

Behaviour:
- Reset state:
  - gnt=0, resp_valid=0, product=0, mul_factor1=0, mul_factor2=0, busy=0.
  - State=IDLE, settle counter=0, last_id=NUM_REQ-1, so requester 0 has top priority after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - If req!=0 at an edge, select the first set bit searching last_id+1, last_id+2, ... modulo NUM_REQ. This winner is id.
  - At that edge: latch id; load mul_factor1/mul_factor2 from the requester's slices; set gnt[id]=1; set last_id=id; load counter=SETTLE_CYCLES-1; go to WAIT.
  - If req==0, stay in IDLE with all pulse outputs at 0.
- WAIT:
  - gnt returns to 0 on the first edge in WAIT; busy=1.
  - If counter!=0, decrement it.
  - If counter==0: product<=mul_product, resp_valid[id]<=1, go to IDLE.
- Timing:
  - resp_valid[id] rises SETTLE_CYCLES cycles after gnt[id] rises.
  - A new grant can be issued on the edge at which resp_valid is high, because the state is IDLE then.
  - Throughput: one multiply per SETTLE_CYCLES+1 cycles.
- Handshake:
  - Operands are sampled only at the grant edge; requesters may change operands or drop req afterwards.
  - req still high after gnt counts as a new request.
  - req changes during WAIT do not affect the operation in flight.
- Arbitration:
  - Simultaneous requests are served strictly round-robin.
  - A requester that is continuously asserting waits at most NUM_REQ-1 other operations.
- mul_factor1/mul_factor2 hold their values until the next grant.
- Reset mid-operation: the operation is aborted, no resp_valid pulse is produced, and all registers return to their reset values immediately.

Optional Feature:
- Macro MULT_ZERO_BYPASS_EN.
- Defined:
  - At a grant edge where either selected operand is 0, skip WAIT: product<=0 and resp_valid[id]<=1 on the same edge as gnt[id]<=1; state stays IDLE.
  - Both pulses are therefore coincident, with zero-cycle latency after the grant.
  - last_id still updates.
- Undefined: zero operands take the normal WAIT path with full latency.

Test Plan:
- Reset, then req=0001, factor1[0]=3, factor2[0]=5, SETTLE_CYCLES=1 -> gnt=0001 for 1 cycle; next cycle resp_valid=0001, product=15; busy high exactly 1 cycle.
- req=1111 held constantly, operands i*1 for requester i (1*1, 2*2, 3*3 taken as i+1 squared) -> grants in order 0001,0010,0100,1000,0001; products 1, 4, 9, 16 returned to the matching resp_valid bit.
- factor1=15, factor2=15 -> product=225 (0xE1), no truncation; with SETTLE_CYCLES=3, resp_valid rises exactly 3 cycles after gnt.
- Assert rst during WAIT of a 7*9 operation -> all outputs 0 asynchronously, no resp_valid, and the next req=1000 is served only after req 0..2 priority positions, so last_id reset is checked.
- Change req_factor1 from 6 to 2 one cycle after gnt (6*4 sampled) -> product=24.
- MULT_ZERO_BYPASS_EN defined, operands 0*9 -> gnt and resp_valid coincident, product=0, busy stays 0; undefined -> normal latency, product=0.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Round-robin arbiter and sequencer that shares one external combinational
//   4x4 unsigned multiplier among NUM_REQ requesters. The winner's operands
//   are registered onto the multiplier inputs. The product is captured after
//   SETTLE_CYCLES and returned with a one-cycle resp_valid pulse.
//
//   Optional build macro: MULT_ZERO_BYPASS_EN
//     When defined, a grant whose operand is zero completes immediately.
//     resp_valid rises together with gnt, product is 0, and the block stays idle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req               request level per requester
//   req_factor1/2     flattened 4-bit operands, requester i at [4i+3:4i]
//   gnt               one-hot grant pulse
//   resp_valid        one-hot result pulse
//   product           last captured product (held)
//   busy              high while an operation is in flight
//   mul_factor1/2     registered operands to the multiplier
//   mul_product       multiplier result
module mult_share_ctrl #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_factor1,
  input  logic [4*NUM_REQ-1:0]   req_factor2,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [7:0]             product,
  output logic                   busy,
  output logic [3:0]             mul_factor1,
  output logic [3:0]             mul_factor2,
  input  logic [7:0]             mul_product
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

`ifdef MULT_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  logic [IDW-1:0] id, last_id, win_id;
  logic [CW-1:0]  cnt;
  logic           win_vld;
  logic [3:0]     win_f1, win_f2;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && req[(int'(last_id) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(last_id) + k) % NUM_REQ);
      end
    end
  end

  assign win_f1 = req_factor1[int'(win_id)*4 +: 4];
  assign win_f2 = req_factor2[int'(win_id)*4 +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      id          <= '0;
      last_id     <= IDW'(NUM_REQ-1);
      cnt         <= '0;
      gnt         <= '0;
      resp_valid  <= '0;
      product     <= '0;
      busy        <= 1'b0;
      mul_factor1 <= '0;
      mul_factor2 <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            id          <= win_id;
            last_id     <= win_id;
            mul_factor1 <= win_f1;
            mul_factor2 <= win_f2;
            gnt         <= ONE << win_id;
            if (ZB && (win_f1 == 4'd0 || win_f2 == 4'd0)) begin
              // Zero product is known up front; no need to wait on the array.
              product    <= '0;
              resp_valid <= ONE << win_id;
            end else begin
              cnt   <= CW'(SETTLE_CYCLES-1);
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            product    <= mul_product;
            resp_valid <= ONE << id;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;
  localparam int N = 4;
  localparam int S = 3;
`ifdef MULT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_factor1, req_factor2;
  logic [N-1:0]   gnt, resp_valid;
  logic [7:0]     product, mul_product;
  logic           busy;
  logic [3:0]     mul_factor1, mul_factor2;

  always #5 clk = ~clk;

  // External multiplier the controller shares.
  assign mul_product = {4'b0, mul_factor1} * {4'b0, mul_factor2};

  mult_share_ctrl #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_factor1(req_factor1), .req_factor2(req_factor2),
    .gnt(gnt), .resp_valid(resp_valid), .product(product), .busy(busy),
    .mul_factor1(mul_factor1), .mul_factor2(mul_factor2),
    .mul_product(mul_product)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view. An operation occupies the
  // shared multiplier for S edges after its grant; while free, the next
  // requester after the previous winner (cyclically) is granted.
  typedef struct { int id; int prod; int cyc; } exp_t;
  exp_t gq[$], rq[$];
  exp_t eg, er;
  int cyc = 0;
  int m_last, m_rem, m_pend, m_prod, m_f1, m_f2, w, a, b;
  bit m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gq.delete(); rq.delete();
      m_last = N-1; m_rem = 0; m_prod = 0; m_f1 = 0; m_f2 = 0; m_busy = 0;
    end else begin
      cyc++;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_prod = m_pend;
      end else if (req != 0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        a = int'((req_factor1 >> (4*w)) & 16'hF);
        b = int'((req_factor2 >> (4*w)) & 16'hF);
        m_last = w; m_f1 = a; m_f2 = b;
        gq.push_back('{w, 0, cyc});
        if (BYP && (a == 0 || b == 0)) begin
          m_prod = 0;
          rq.push_back('{w, 0, cyc});
        end else begin
          m_pend = a * b;
          m_rem  = S;
          rq.push_back('{w, a * b, cyc + S});
        end
      end
      m_busy = (m_rem > 0);
    end
  end

  // Monitor: pops expectations whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (!rst) begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        eg = gq.pop_front();
        chk("gnt_missing", 32'(gnt), 32'(1 << eg.id));
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        er = rq.pop_front();
        chk("resp_missing", 32'(resp_valid), 32'(1 << er.id));
      end
      if (gnt != 0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
        else begin
          eg = gq.pop_front();
          chk("gnt_id", 32'(gnt), 32'(1 << eg.id));
          chk("gnt_cycle", cyc, eg.cyc);
        end
      end
      if (resp_valid != 0) begin
        if (rq.size() == 0) chk("resp_unexpected", 32'(resp_valid), 0);
        else begin
          er = rq.pop_front();
          chk("resp_id", 32'(resp_valid), 32'(1 << er.id));
          chk("resp_cycle", cyc, er.cyc);
          chk("resp_product", 32'(product), er.prod);
        end
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mul_factor1", 32'(mul_factor1), m_f1);
      chk("mul_factor2", 32'(mul_factor2), m_f2);
      chk("product_hold", 32'(product), m_prod);
    end
  end

  task automatic set_op(input int i, input logic [3:0] fa, input logic [3:0] fb);
    req_factor1[4*i +: 4] = fa;
    req_factor2[4*i +: 4] = fb;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 0);
    chk({nm, "_resp"}, 32'(resp_valid), 0);
    chk({nm, "_product"}, 32'(product), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_mf1"}, 32'(mul_factor1), 0);
    chk({nm, "_mf2"}, 32'(mul_factor2), 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_factor1 = '0; req_factor2 = '0;
    #12 chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    idle(2);

    // Single request 3*5.
    set_op(0, 3, 5); req = 4'b0001;
    @(negedge clk) req = '0;
    idle(S + 2);

    // All requesters held: round-robin 0,1,2,3,0...
    for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'(i + 1));
    req = 4'b1111;
    idle(5 * (S + 1));
    req = '0;
    idle(S + 2);

    // Largest product, no truncation.
    set_op(2, 15, 15); req = 4'b0100;
    @(negedge clk) req = '0;
    idle(S + 2);

    // Operand changed after the grant edge must not matter.
    set_op(1, 6, 4); req = 4'b0010;
    @(negedge clk) begin req = '0; set_op(1, 2, 4); end
    idle(S + 2);

    // Reset in the middle of a 7*9 operation.
    set_op(1, 7, 9); req = 4'b0010;
    @(negedge clk) req = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 4'(i + 2), 4'(i + 3));
    req = 4'b1111;
    idle(4 * (S + 1));
    req = '0;
    idle(S + 2);

    // Zero operand.
    set_op(3, 0, 9); req = 4'b1000;
    @(negedge clk) req = '0;
    idle(S + 2);

    // Randomized traffic.
    repeat (400) begin
      @(negedge clk);
      req = N'($urandom);
      req_factor1 = (4*N)'($urandom);
      req_factor2 = (4*N)'($urandom);
    end
    req = '0;
    idle(2 * S + 4);
    chk("grant_queue_drained", gq.size(), 0);
    chk("resp_queue_drained", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
